// File: rtl/l2_cache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back L2 cache: tree-PLRU replacement,
// invalid-way-first victim choice, memory retry back-off and saturating hit/miss counters.
module l2_cache_ctrl_nway #(
  parameter int WAYS      = 4,
  parameter int RETRY_GAP = 2,
  parameter int CNT_W     = 32,
  localparam int WL       = $clog2(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hit,
  input  logic [WL-1:0]    i_hit_way,
  input  logic [WAYS-1:0]  i_valid_vec,
  input  logic [WAYS-1:0]  i_dirty_vec,
  input  logic [WAYS-2:0]  i_lru_out,
  output logic             o_lru_write,
  output logic [WAYS-2:0]  o_lru_in,
  output logic [WAYS-1:0]  o_valid_we,
  output logic [WAYS-1:0]  o_dirty_we,
  output logic [WAYS-1:0]  o_tag_we,
  output logic [WAYS-1:0]  o_data_we,
  output logic             o_valid_in,
  output logic             o_dirty_in,
  output logic [WL-1:0]    o_way_sel,
  output logic             o_pmem_addr_sig,
  output logic             o_data_sig,
  input  logic             i_cpu_action_stb,
  input  logic             i_cpu_action_cyc,
  input  logic             i_cpu_write,
  output logic             o_cpu_resp,
  output logic             o_cpu_retry,
  output logic             o_mem_action_stb,
  output logic             o_mem_action_cyc,
  output logic             o_mem_write,
  input  logic             i_mem_resp,
  input  logic             i_mem_retry,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int GW = $clog2(RETRY_GAP + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_BO   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_target;
  logic [WL-1:0]    r_victim;
  logic [GW-1:0]    r_gap;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_req;
  logic [WL-1:0]    w_victim;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAYS-1:0]  w_victim_oh;

  // Node at level l on the path to way w sits at (2^l - 1) + (w >> (WL - l)).
  function automatic logic [WAYS-2:0] f_plru_update(input logic [WAYS-2:0] lru,
                                                    input logic [WL-1:0] way);
    logic [WAYS-2:0] upd;
    int idx;
    logic b;
    upd = lru;
    for (int l = 0; l < WL; l++) begin
      idx = (32'sd1 <<< l) - 32'sd1 + (int'(way) >> (WL - l));
      b   = way[WL-1-l];
      for (int n = 0; n < WAYS - 1; n++) begin
        upd[n] = (n == idx) ? b : upd[n];
      end
    end
    return upd;
  endfunction

  function automatic logic [WL-1:0] f_plru_victim(input logic [WAYS-2:0] lru);
    int pre;
    int idx;
    logic b;
    pre = 0;
    for (int l = 0; l < WL; l++) begin
      idx = (32'sd1 <<< l) - 32'sd1 + pre;
      b   = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        b = (n == idx) ? ~lru[n] : b;
      end
      pre = pre * 32'sd2 + int'(b);
    end
    return pre[WL-1:0];
  endfunction

  assign w_req       = i_cpu_action_stb & i_cpu_action_cyc;
  assign w_hit_oh    = WAYS'(1) << i_hit_way;
  assign w_victim_oh = WAYS'(1) << r_victim;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;
  assign o_cpu_retry = w_req & ~o_cpu_resp;

  // Victim: lowest-index invalid way, otherwise the PLRU choice.
  always_comb begin
    w_victim = f_plru_victim(i_lru_out);
    for (int i = WAYS - 1; i >= 0; i--) begin
      w_victim = i_valid_vec[i] ? w_victim : i[WL-1:0];
    end
  end

  // State-decoded array, CPU and memory controls.
  always_comb begin
    o_lru_write      = 1'b0;
    o_lru_in         = i_lru_out;
    o_valid_we       = {WAYS{1'b0}};
    o_dirty_we       = {WAYS{1'b0}};
    o_tag_we         = {WAYS{1'b0}};
    o_data_we        = {WAYS{1'b0}};
    o_valid_in       = 1'b0;
    o_dirty_in       = 1'b0;
    o_way_sel        = {WL{1'b0}};
    o_pmem_addr_sig  = 1'b0;
    o_data_sig       = 1'b0;
    o_cpu_resp       = 1'b0;
    o_mem_action_stb = 1'b0;
    o_mem_action_cyc = 1'b0;
    o_mem_write      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && i_hit) begin
          o_cpu_resp  = 1'b1;
          o_lru_write = 1'b1;
          o_lru_in    = f_plru_update(i_lru_out, i_hit_way);
          if (i_cpu_write) begin
            o_data_we  = w_hit_oh;
            o_dirty_we = w_hit_oh;
            o_dirty_in = 1'b1;
          end else begin
            o_data_we  = {WAYS{1'b0}};
          end
        end else begin
          o_cpu_resp = 1'b0;
        end
      end
      S_WB: begin
        o_mem_action_stb = 1'b1;
        o_mem_action_cyc = 1'b1;
        o_mem_write      = 1'b1;
        o_pmem_addr_sig  = 1'b1;
        o_way_sel        = r_victim;
      end
      S_RD: begin
        o_mem_action_stb = 1'b1;
        o_mem_action_cyc = 1'b1;
        o_data_sig       = 1'b1;
        o_way_sel        = r_victim;
        if (i_mem_resp) begin
          o_tag_we   = w_victim_oh;
          o_data_we  = w_victim_oh;
          o_valid_we = w_victim_oh;
          o_dirty_we = w_victim_oh;
          o_valid_in = 1'b1;
        end else begin
          o_valid_in = 1'b0;
        end
      end
      S_BO: begin
        o_way_sel = r_victim;
      end
      default: begin
        o_way_sel = {WL{1'b0}};
      end
    endcase
  end

  // FSM, frozen victim, back-off counter and saturating statistics.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_target   <= S_IDLE;
      r_victim   <= {WL{1'b0}};
      r_gap      <= {GW{1'b0}};
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && i_hit) begin
            if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else if (w_req) begin
            r_victim <= w_victim;
            if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            r_state  <= (i_dirty_vec[w_victim] & i_valid_vec[w_victim]) ? S_WB : S_RD;
          end
        end
        S_WB: begin
          if (i_mem_resp) begin
            r_state <= S_RD;
          end else if (i_mem_retry) begin
            r_state  <= S_BO;
            r_target <= S_WB;
            r_gap    <= {GW{1'b0}};
          end
        end
        S_RD: begin
          if (i_mem_resp) begin
            r_state <= S_IDLE;
          end else if (i_mem_retry) begin
            r_state  <= S_BO;
            r_target <= S_RD;
            r_gap    <= {GW{1'b0}};
          end
        end
        S_BO: begin
          if (r_gap == GW'(RETRY_GAP - 1)) begin
            r_state <= r_target;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Self-checking bench for l2_cache_ctrl_nway: a 4-way instance for hits, misses, retry and reset,
// and an 8-way instance with 2-bit counters for the PLRU fill and saturation cases.
module tb_l2_cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       hit, cpu_write, stb, cyc, mem_resp, mem_retry;
  logic [1:0] hit_way;
  logic [3:0] valid_vec, dirty_vec;
  logic [2:0] lru_out, lru_in;
  logic       lru_write, valid_in, dirty_in, pmem_addr_sig, data_sig;
  logic [3:0] valid_we, dirty_we, tag_we, data_we;
  logic [1:0] way_sel;
  logic       cpu_resp, cpu_retry, mem_stb, mem_cyc, mem_write;
  logic [31:0] hit_cnt, miss_cnt;

  logic       e_hit, e_stb, e_cyc, e_mem_resp;
  logic [2:0] e_hit_way, e_way_sel;
  logic [7:0] e_valid, e_dirty, e_valid_we, e_dirty_we, e_tag_we, e_data_we;
  logic [6:0] e_lru, e_lru_in;
  logic       e_lru_write, e_valid_in, e_dirty_in, e_pmem, e_dsig;
  logic       e_cpu_resp, e_cpu_retry, e_mem_stb, e_mem_cyc, e_mem_write;
  logic [1:0] e_hit_cnt, e_miss_cnt;

  l2_cache_ctrl_nway #(.WAYS(4), .RETRY_GAP(2), .CNT_W(32)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_hit(hit), .i_hit_way(hit_way),
    .i_valid_vec(valid_vec), .i_dirty_vec(dirty_vec), .i_lru_out(lru_out),
    .o_lru_write(lru_write), .o_lru_in(lru_in),
    .o_valid_we(valid_we), .o_dirty_we(dirty_we), .o_tag_we(tag_we), .o_data_we(data_we),
    .o_valid_in(valid_in), .o_dirty_in(dirty_in), .o_way_sel(way_sel),
    .o_pmem_addr_sig(pmem_addr_sig), .o_data_sig(data_sig),
    .i_cpu_action_stb(stb), .i_cpu_action_cyc(cyc), .i_cpu_write(cpu_write),
    .o_cpu_resp(cpu_resp), .o_cpu_retry(cpu_retry),
    .o_mem_action_stb(mem_stb), .o_mem_action_cyc(mem_cyc), .o_mem_write(mem_write),
    .i_mem_resp(mem_resp), .i_mem_retry(mem_retry),
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt));

  l2_cache_ctrl_nway #(.WAYS(8), .RETRY_GAP(2), .CNT_W(2)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_hit(e_hit), .i_hit_way(e_hit_way),
    .i_valid_vec(e_valid), .i_dirty_vec(e_dirty), .i_lru_out(e_lru),
    .o_lru_write(e_lru_write), .o_lru_in(e_lru_in),
    .o_valid_we(e_valid_we), .o_dirty_we(e_dirty_we), .o_tag_we(e_tag_we), .o_data_we(e_data_we),
    .o_valid_in(e_valid_in), .o_dirty_in(e_dirty_in), .o_way_sel(e_way_sel),
    .o_pmem_addr_sig(e_pmem), .o_data_sig(e_dsig),
    .i_cpu_action_stb(e_stb), .i_cpu_action_cyc(e_cyc), .i_cpu_write(1'b0),
    .o_cpu_resp(e_cpu_resp), .o_cpu_retry(e_cpu_retry),
    .o_mem_action_stb(e_mem_stb), .o_mem_action_cyc(e_mem_cyc), .o_mem_write(e_mem_write),
    .i_mem_resp(e_mem_resp), .i_mem_retry(1'b0),
    .o_hit_cnt(e_hit_cnt), .o_miss_cnt(e_miss_cnt));

  typedef struct {
    logic       wr;
    logic [1:0] way;
    logic [2:0] lru;
    logic [2:0] exp_lru;
    logic [3:0] exp_we;
    logic       exp_din;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ncyc;

  // Fill monitor: every valid_we pulse of the 4-way instance is recorded.
  always @(negedge clk) begin
    if (valid_we != 4'b0000) obs_q.push_back(valid_we);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string name);
    logic [3:0] e, o;
    chk({name, "_fill_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({name, "_fill_way"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Serves memory with a fixed latency (stb-high cycles incl. the resp cycle) until cpu_resp.
  task automatic run_miss(input int lat, input logic [1:0] way, output int cycles);
    int   sc;
    logic fp;
    sc = 0; fp = 1'b0; cycles = 0;
    stb = 1'b1; cyc = 1'b1; hit = 1'b0; hit_way = way;
    #1;
    while (!cpu_resp && cycles < 40) begin
      nxt();
      cycles++;
      hit = fp;
      if (mem_stb) sc++; else sc = 0;
      mem_resp = (sc == lat);
      fp = mem_resp & ~mem_write;
      if (mem_resp) sc = 0;
      #1;
    end
    mem_resp = 1'b0; stb = 1'b0; cyc = 1'b0; hit = 1'b0;
    nxt();
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 3'b000, 3'b001, 4'b0000, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 3'b111, 3'b100, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 3'b000, 3'b010, 4'b0010, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 3'b000, 3'b101, 4'b1000, 1'b1};
    vecs[4] = '{1'b0, 2'd2, 3'b111, 3'b011, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 3'b101, 3'b110, 4'b0010, 1'b1};

    rst = 1'b1; hit = 1'b0; hit_way = 2'd0; cpu_write = 1'b0; mem_resp = 1'b0; mem_retry = 1'b0;
    valid_vec = 4'b1111; dirty_vec = 4'b0000; lru_out = 3'b000; stb = 1'b1; cyc = 1'b1;
    e_hit = 1'b0; e_stb = 1'b0; e_cyc = 1'b0; e_mem_resp = 1'b0; e_hit_way = 3'd0;
    e_valid = 8'hFF; e_dirty = 8'h00; e_lru = 7'h7F;
    #12;
    chk("rst_mem_stb", mem_stb, 1'b0);
    chk("rst_cpu_resp", cpu_resp, 1'b0);
    chk("rst_cpu_retry", cpu_retry, 1'b1);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    nxt();
    rst = 1'b0;
    nxt();

    // Back-to-back hits from the vector table.
    for (int i = 0; i < 6; i++) begin
      stb = 1'b1; cyc = 1'b1; hit = 1'b1;
      hit_way = vecs[i].way; cpu_write = vecs[i].wr; lru_out = vecs[i].lru;
      #1;
      chk($sformatf("hit%0d_resp", i), cpu_resp, 1'b1);
      chk($sformatf("hit%0d_retry", i), cpu_retry, 1'b0);
      chk($sformatf("hit%0d_lru_write", i), lru_write, 1'b1);
      chk($sformatf("hit%0d_lru_in", i), lru_in, vecs[i].exp_lru);
      chk($sformatf("hit%0d_data_we", i), data_we, vecs[i].exp_we);
      chk($sformatf("hit%0d_dirty_we", i), dirty_we, vecs[i].exp_we);
      chk($sformatf("hit%0d_dirty_in", i), dirty_in, vecs[i].exp_din);
      nxt();
      chk($sformatf("hit%0d_hit_cnt", i), hit_cnt, i + 1);
    end
    stb = 1'b0; cyc = 1'b0; hit = 1'b0; cpu_write = 1'b0;
    nxt();

    // Clean miss with an invalid way: victim 2 although PLRU points at way 3.
    stb = 1'b1; cyc = 1'b1; valid_vec = 4'b1011; dirty_vec = 4'b0000; lru_out = 3'b000;
    exp_q.push_back(4'b0100);
    #1;
    chk("missA_resp", cpu_resp, 1'b0);
    chk("missA_retry", cpu_retry, 1'b1);
    nxt();
    valid_vec = 4'b1111; lru_out = 3'b111;
    #1;
    chk("missA_rd_stb", mem_stb, 1'b1);
    chk("missA_rd_write", mem_write, 1'b0);
    chk("missA_rd_data_sig", data_sig, 1'b1);
    chk("missA_way_sel", way_sel, 2'd2);
    chk("missA_miss_cnt", miss_cnt, 32'd1);
    nxt();
    mem_resp = 1'b1;
    #1;
    chk("missA_tag_we", tag_we, 4'b0100);
    chk("missA_dirty_we", dirty_we, 4'b0100);
    chk("missA_valid_in", valid_in, 1'b1);
    chk("missA_dirty_in", dirty_in, 1'b0);
    nxt();
    mem_resp = 1'b0; hit = 1'b1; hit_way = 2'd2;
    #1;
    chk("missA_replay_resp", cpu_resp, 1'b1);
    chk("missA_idle_stb", mem_stb, 1'b0);
    nxt();
    stb = 1'b0; cyc = 1'b0; hit = 1'b0;
    nxt();
    sb_check("missA");

    // Dirty miss with retry in WB, then simultaneous resp+retry in RD.
    stb = 1'b1; cyc = 1'b1; valid_vec = 4'b1111; dirty_vec = 4'b1111; lru_out = 3'b000;
    exp_q.push_back(4'b1000);
    nxt();
    mem_retry = 1'b1;
    #1;
    chk("wb_stb", mem_stb, 1'b1);
    chk("wb_write", mem_write, 1'b1);
    chk("wb_pmem_addr", pmem_addr_sig, 1'b1);
    chk("wb_way_sel", way_sel, 2'd3);
    nxt();
    mem_retry = 1'b0;
    #1;
    chk("bo1_stb", mem_stb, 1'b0);
    chk("bo1_cyc", mem_cyc, 1'b0);
    nxt();
    chk("bo2_stb", mem_stb, 1'b0);
    nxt();
    chk("wb_reissue_stb", mem_stb, 1'b1);
    chk("wb_reissue_write", mem_write, 1'b1);
    mem_resp = 1'b1;
    nxt();
    mem_retry = 1'b1;
    #1;
    chk("rd_after_wb_write", mem_write, 1'b0);
    chk("rd_after_wb_pmem", pmem_addr_sig, 1'b0);
    chk("rd_resp_retry_fill", valid_we, 4'b1000);
    nxt();
    mem_resp = 1'b0; mem_retry = 1'b0; hit = 1'b1; hit_way = 2'd3;
    #1;
    chk("rd_resp_wins_idle", mem_stb, 1'b0);
    chk("wb_replay_resp", cpu_resp, 1'b1);
    nxt();
    stb = 1'b0; cyc = 1'b0; hit = 1'b0;
    nxt();
    sb_check("missB");

    // Latency: clean miss L+1, dirty miss 2L+1 with L = 3.
    dirty_vec = 4'b0000; lru_out = 3'b111;
    exp_q.push_back(4'b0001);
    run_miss(3, 2'd0, ncyc);
    chk("lat_clean", ncyc, 32'd4);
    sb_check("latC");
    dirty_vec = 4'b0001;
    exp_q.push_back(4'b0001);
    run_miss(3, 2'd0, ncyc);
    chk("lat_dirty", ncyc, 32'd7);
    sb_check("latD");

    // Request dropped during WB: fill still happens, no response.
    dirty_vec = 4'b1111; lru_out = 3'b101; stb = 1'b1; cyc = 1'b1;
    exp_q.push_back(4'b0010);
    nxt();
    cyc = 1'b0; mem_resp = 1'b1;
    #1;
    chk("drop_wb_stb", mem_stb, 1'b1);
    chk("drop_wb_resp", cpu_resp, 1'b0);
    chk("drop_wb_retry", cpu_retry, 1'b0);
    nxt();
    chk("drop_rd_fill", valid_we, 4'b0010);
    chk("drop_rd_resp", cpu_resp, 1'b0);
    nxt();
    mem_resp = 1'b0; stb = 1'b0;
    #1;
    chk("drop_idle_stb", mem_stb, 1'b0);
    nxt();
    sb_check("drop");

    // Reset during RD.
    valid_vec = 4'b0000; dirty_vec = 4'b0000; stb = 1'b1; cyc = 1'b1;
    nxt();
    chk("rstmid_rd_stb", mem_stb, 1'b1);
    stb = 1'b0; cyc = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_async_stb", mem_stb, 1'b0);
    chk("rstmid_hit_cnt", hit_cnt, 32'd0);
    chk("rstmid_miss_cnt", miss_cnt, 32'd0);
    nxt();
    rst = 1'b0;
    nxt();
    chk("rstmid_idle_stb", mem_stb, 1'b0);
    sb_check("rstmid");

    // 8-way: all valid, clean, PLRU all ones -> way 0; then counter saturation.
    e_stb = 1'b1; e_cyc = 1'b1;
    nxt();
    chk("w8_rd_stb", e_mem_stb, 1'b1);
    chk("w8_way_sel", e_way_sel, 3'd0);
    e_mem_resp = 1'b1;
    #1;
    chk("w8_valid_we", e_valid_we, 8'h01);
    chk("w8_tag_we", e_tag_we, 8'h01);
    chk("w8_data_we", e_data_we, 8'h01);
    chk("w8_dirty_we", e_dirty_we, 8'h01);
    nxt();
    e_mem_resp = 1'b0; e_hit = 1'b1;
    #1;
    chk("w8_replay_resp", e_cpu_resp, 1'b1);
    chk("w8_lru_in", e_lru_in, 7'h74);
    nxt();
    e_stb = 1'b0; e_cyc = 1'b0;
    #1;
    chk("w8_single_resp", e_cpu_resp, 1'b0);
    chk("w8_miss_cnt", e_miss_cnt, 2'd1);
    chk("w8_hit_cnt", e_hit_cnt, 2'd1);
    for (int i = 0; i < 3; i++) begin
      e_stb = 1'b1; e_cyc = 1'b1;
      nxt();
    end
    e_stb = 1'b0; e_cyc = 1'b0;
    #1;
    chk("w8_hit_saturate", e_hit_cnt, 2'd3);
    chk("w8_miss_hold", e_miss_cnt, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
